// File: rtl/dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dpram_fifo_ctrl
// Purpose  : FIFO controller in front of a two-port RAM with registered,
//            tri-stated read data. Turns push valid/ready and pop request
//            handshakes into RAM write/read strobes, captures RAM read data
//            into a registered pop port, and keeps occupancy, status flags
//            and sticky error flags.
// Ports    : clk, reset_n (async, active low)
//            push/push_data/push_ready    - write side handshake
//            pop/pop_ready/pop_data/pop_valid - read side handshake + data
//            ram_wr_en/ram_wr_addr/ram_wr_data, ram_out_en/ram_rd_addr,
//            ram_q                        - RAM control and read data
//            count, full, empty, almost_full, almost_empty - occupancy
//            overflow, underflow, clr_err - sticky errors and their clear
// Revision : 1.0 - initial release
// ============================================================================
module dpram_fifo_ctrl #(
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 16,
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [DATA_SIZE-1:0]       push_data,
  output logic                       push_ready,
  input  logic                       pop,
  output logic                       pop_ready,
  output logic [DATA_SIZE-1:0]       pop_data,
  output logic                       pop_valid,
  output logic                       ram_wr_en,
  output logic                       ram_out_en,
  output logic [$clog2(DEPTH)-1:0]   ram_wr_addr,
  output logic [$clog2(DEPTH)-1:0]   ram_rd_addr,
  output logic [DATA_SIZE-1:0]       ram_wr_data,
  input  logic [DATA_SIZE-1:0]       ram_q,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] C_AE   = CNT_W'(AE_LEVEL);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RD   = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_SIZE-1:0]  pop_data_q, pop_data_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic                  w_idle;

  // Flags come straight from the registered count.
  assign full         = (count_q == C_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= C_AF);
  assign almost_empty = (count_q <= C_AE);
  assign count        = count_q;

  assign w_idle     = (state_q == ST_IDLE);
  assign push_ready = w_idle && !full;
  assign pop_ready  = w_idle && !empty;
  assign w_push_acc = push && push_ready;
  assign w_pop_acc  = pop && pop_ready;

  // RAM drive. During RD the captured address keeps q_out driven.
  // When not writing, the write address aliases the read address so the
  // RAM's "copy wr_addr to rd_addr" behaviour with wr_en low is a no-op.
  assign ram_wr_en   = w_push_acc;
  assign ram_wr_data = push_data;
  assign ram_out_en  = w_pop_acc || (state_q == ST_RD);
  assign ram_rd_addr = (state_q == ST_RD) ? rd_addr_q : rd_ptr_q;
  assign ram_wr_addr = w_push_acc ? wr_ptr_q : ram_rd_addr;

  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_addr_d   = rd_addr_q;
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    case (state_q)
      ST_IDLE: if (w_pop_acc) state_d = ST_RD;
      ST_RD: begin
        // Capture edge: RAM has been presenting the word for this cycle.
        state_d     = ST_IDLE;
        pop_data_d  = ram_q;
        pop_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_push_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (w_pop_acc) begin
      rd_addr_d = rd_ptr_q;
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
    end

    if (w_push_acc && !w_pop_acc)      count_d = count_q + CNT_W'(1);
    else if (w_pop_acc && !w_push_acc) count_d = count_q - CNT_W'(1);

    // A new error condition takes priority over the clear.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (push && full)          overflow_d  = 1'b1;
    if (pop && empty && w_idle) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_addr_q   <= '0;
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_addr_q   <= rd_addr_d;
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_fifo_ctrl
// Purpose  : Directed self-checking bench for dpram_fifo_ctrl, with a
//            behavioural two-port RAM (registered, tri-stated read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_fifo_ctrl;

  localparam int DW = 16;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          push_ready, pop_ready, pop_valid;
  logic [DW-1:0] pop_data, ram_wr_data;
  wire  [DW-1:0] ram_q;
  logic          ram_wr_en, ram_out_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  int checks = 0;
  int failures = 0;

  dpram_fifo_ctrl #(.DATA_SIZE(DW), .DEPTH(DP)) dut (
    .clk(clk), .reset_n(reset_n),
    .push(push), .push_data(push_data), .push_ready(push_ready),
    .pop(pop), .pop_ready(pop_ready), .pop_data(pop_data), .pop_valid(pop_valid),
    .ram_wr_en(ram_wr_en), .ram_out_en(ram_out_en),
    .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
    .ram_wr_data(ram_wr_data), .ram_q(ram_q),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Two-port RAM model: with wr_en low it copies mem[wr_addr] to
  // mem[rd_addr], so a broken address alias corrupts stored data.
  logic [DW-1:0] mem [DP];
  logic [DW-1:0] q_reg;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    else           mem[ram_rd_addr] <= mem[ram_wr_addr];
    if (ram_out_en) q_reg <= mem[ram_rd_addr];
  end
  assign ram_q = ram_out_en ? q_reg : 'z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Address aliasing must hold in every non-writing cycle.
  always @(negedge clk) begin
    #4;
    if (reset_n && !ram_wr_en) chk("alias", 32'(ram_wr_addr), 32'(ram_rd_addr));
  end

  task automatic do_push(input logic [DW-1:0] d, input int exp_addr);
    @(negedge clk); push = 1'b1; push_data = d; #1;
    chk("push_we", 32'(ram_wr_en), 32'd1);
    chk("push_addr", 32'(ram_wr_addr), 32'(exp_addr));
    @(negedge clk); push = 1'b0;
  endtask

  task automatic do_pop(input logic [DW-1:0] d, input int exp_addr);
    @(negedge clk); pop = 1'b1; #1;
    chk("pop_oe", 32'(ram_out_en), 32'd1);
    chk("pop_addr", 32'(ram_rd_addr), 32'(exp_addr));
    @(negedge clk); pop = 1'b0; #1;
    chk("rd_no_we", 32'(ram_wr_en), 32'd0);
    chk("rd_valid_lo", 32'(pop_valid), 32'd0);
    @(negedge clk); #1;
    chk("pop_valid", 32'(pop_valid), 32'd1);
    chk("pop_data", 32'(pop_data), 32'(d));
  endtask

  task automatic chk_reset_state();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    chk("rst_pop_ready", 32'(pop_ready), 32'd0);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_pop_data", 32'(pop_data), 32'd0);
    chk("rst_we", 32'(ram_wr_en), 32'd0);
    chk("rst_oe", 32'(ram_out_en), 32'd0);
    chk("rst_wa", 32'(ram_wr_addr), 32'd0);
    chk("rst_ra", 32'(ram_rd_addr), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
  endtask

  initial begin
    // Reset
    #3;
    chk_reset_state();
    @(negedge clk); reset_n = 1'b1;

    // Fill 0x0001..0x0010
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); push = 1'b1; push_data = DW'(i + 1); #1;
      chk("fill_ready", 32'(push_ready), 32'd1);
      chk("fill_we", 32'(ram_wr_en), 32'd1);
      chk("fill_addr", 32'(ram_wr_addr), 32'(i));
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_af", 32'(almost_full), (i >= 14) ? 32'd1 : 32'd0);
    end
    @(negedge clk); push = 1'b0; #1;
    chk("full_count", 32'(count), 32'd16);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_af", 32'(almost_full), 32'd1);
    chk("full_push_ready", 32'(push_ready), 32'd0);
    chk("full_no_ovf", 32'(overflow), 32'd0);

    // Overflow and clear
    @(negedge clk); push = 1'b1; push_data = 16'hDEAD; #1;
    chk("ovf_no_we", 32'(ram_wr_en), 32'd0);
    @(negedge clk); push = 1'b0; #1;
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_set", 32'(overflow), 32'd1);
    @(negedge clk); #1;
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0; #1;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Drain with pop held high: one accept every other cycle
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); pop = 1'b1; #1;
      chk("drain_ready", 32'(pop_ready), 32'd1);
      chk("drain_addr", 32'(ram_rd_addr), 32'(k));
      if (k > 0) begin
        chk("drain_valid", 32'(pop_valid), 32'd1);
        chk("drain_data", 32'(pop_data), 32'(k));
      end
      @(negedge clk); #1;
      chk("drain_rd_valid", 32'(pop_valid), 32'd0);
      chk("drain_rd_pr", 32'(pop_ready), 32'd0);
      chk("drain_rd_we", 32'(ram_wr_en), 32'd0);
      chk("drain_count", 32'(count), 32'(15 - k));
    end
    @(negedge clk); pop = 1'b0; #1;
    chk("drain_last_valid", 32'(pop_valid), 32'd1);
    chk("drain_last_data", 32'(pop_data), 32'h10);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_no_unf", 32'(underflow), 32'd0);

    // Wrap-around: pointers start at 0 after the full drain
    for (int i = 0; i < 10; i++) do_push(DW'(16'h0100 + i), i);
    for (int i = 0; i < 10; i++) do_pop(DW'(16'h0100 + i), i);
    for (int i = 0; i < 12; i++) do_push(DW'(16'h0200 + i), (10 + i) % 16);
    chk("wrap_count", 32'(count), 32'd12);
    for (int i = 0; i < 12; i++) do_pop(DW'(16'h0200 + i), (10 + i) % 16);

    // Simultaneous push and pop with count=5 (wr_ptr=11, rd_ptr=6)
    for (int i = 0; i < 5; i++) do_push(DW'(16'h0300 + i), (6 + i) % 16);
    @(negedge clk); push = 1'b1; push_data = 16'hA5A5; pop = 1'b1; #1;
    chk("sim_we", 32'(ram_wr_en), 32'd1);
    chk("sim_oe", 32'(ram_out_en), 32'd1);
    chk("sim_wa", 32'(ram_wr_addr), 32'd11);
    chk("sim_ra", 32'(ram_rd_addr), 32'd6);
    @(negedge clk); push_data = 16'hBEEF; pop = 1'b0; #1;
    chk("sim_rd_push_ready", 32'(push_ready), 32'd0);
    chk("sim_rd_we", 32'(ram_wr_en), 32'd0);
    chk("sim_count", 32'(count), 32'd5);
    @(negedge clk); push = 1'b0; #1;
    chk("sim_valid", 32'(pop_valid), 32'd1);
    chk("sim_data", 32'(pop_data), 32'h0300);
    chk("sim_no_ovf", 32'(overflow), 32'd0);
    chk("sim_count2", 32'(count), 32'd5);
    for (int i = 1; i < 5; i++) do_pop(DW'(16'h0300 + i), 6 + i);
    do_pop(16'hA5A5, 11);
    chk("sim_empty", 32'(empty), 32'd1);

    // Underflow
    @(negedge clk); pop = 1'b1; #1;
    chk("unf_no_oe", 32'(ram_out_en), 32'd0);
    @(negedge clk); pop = 1'b0; #1;
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    // Pop while empty with a simultaneous push: only the push lands
    @(negedge clk); pop = 1'b1; push = 1'b1; push_data = 16'h1234; #1;
    chk("unf_push_we", 32'(ram_wr_en), 32'd1);
    chk("unf_push_oe", 32'(ram_out_en), 32'd0);
    @(negedge clk); pop = 1'b0; push = 1'b0; clr_err = 1'b1; #1;
    chk("unf_push_count", 32'(count), 32'd1);
    @(negedge clk); clr_err = 1'b0; #1;
    chk("unf_clr", 32'(underflow), 32'd0);

    // Reset during RD: in-flight word discarded
    @(negedge clk); pop = 1'b1; #1;
    chk("mid_oe", 32'(ram_out_en), 32'd1);
    @(negedge clk); pop = 1'b0; #2;
    reset_n = 1'b0; #1;
    chk_reset_state();
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); #1;
    chk("mid_no_valid", 32'(pop_valid), 32'd0);
    chk("mid_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
